// File: rtl/alu_muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit.
//   op_e        : RV32M operation codes (MUL=0 ... REMU=7)
//   state_e     : controller states IDLE, BUSY, FIXUP, DONE
//   step_mode_e : selects multiply or divide iteration in muldiv_step
// Optional build macro used by alu_muldiv: MULDIV_EARLY_OUT_EN.
package alu_muldiv_pkg;

  typedef enum logic [2:0] {
    OP_MUL    = 3'd0,
    OP_MULH   = 3'd1,
    OP_MULHSU = 3'd2,
    OP_MULHU  = 3'd3,
    OP_DIV    = 3'd4,
    OP_DIVU   = 3'd5,
    OP_REM    = 3'd6,
    OP_REMU   = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    FIXUP,
    DONE
  } state_e;

  typedef enum logic {
    STEP_MUL,
    STEP_DIV
  } step_mode_e;

  function automatic logic is_div(input op_e o);
    return o inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
  endfunction

  // rs1 is treated as signed for MULH, MULHSU, DIV, REM.
  function automatic logic rs1_signed(input op_e o);
    return o inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
  endfunction

  // rs2 is treated as signed for MULH, DIV, REM (not MULHSU).
  function automatic logic rs2_signed(input op_e o);
    return o inside {OP_MULH, OP_DIV, OP_REM};
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the shift-add multiplier or restoring divider.
// Purely combinational.
//   mode     : STEP_MUL or STEP_DIV
//   acc      : product high half (mul) / partial remainder (div)
//   opnd     : multiplicand magnitude (mul) / divisor magnitude (div)
//   quo      : multiplier / product low half (mul), dividend / quotient (div)
//   acc_next, quo_next : register values for the next iteration
module muldiv_step
  import alu_muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  step_mode_e       mode,
  input  logic [WIDTH-1:0] acc,
  input  logic [WIDTH-1:0] opnd,
  input  logic [WIDTH-1:0] quo,
  output logic [WIDTH-1:0] acc_next,
  output logic [WIDTH-1:0] quo_next
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  always_comb begin
    sum      = '0;
    shifted  = '0;
    diff     = '0;
    acc_next = acc;
    quo_next = quo;
    if (mode == STEP_DIV) begin
      // Remainder stays below the divisor, so WIDTH+1 bits hold the
      // difference and its top bit is the borrow.
      shifted = {acc, quo[WIDTH-1]};
      diff    = shifted - {1'b0, opnd};
      if (diff[WIDTH]) begin
        acc_next = shifted[WIDTH-1:0];
        quo_next = {quo[WIDTH-2:0], 1'b0};
      end else begin
        acc_next = diff[WIDTH-1:0];
        quo_next = {quo[WIDTH-2:0], 1'b1};
      end
    end else begin
      // {acc, quo} is the product register; the carry re-enters at the top.
      sum      = {1'b0, acc} + ({1'b0, opnd} & {(WIDTH+1){quo[0]}});
      acc_next = sum[WIDTH:1];
      quo_next = {sum[0], quo[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/alu_muldiv.sv
// Multi-cycle RV32M multiply/divide unit with valid/ready handshake.
//   clk, rst (sync, active high), flush (sync kill of in-flight op)
//   in_valid / in_ready : request handshake, in_ready high only in IDLE
//   op [2:0], in1, in2  : operation and rs1/rs2 operands
//   out_valid / out_ready, out : result handshake and registered result
// Optional macro MULDIV_EARLY_OUT_EN: divide-by-zero, signed overflow and
// multiply-by-zero results are produced at the accepting edge.
module alu_muldiv
  import alu_muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out
);

  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_e           state, state_n;
  op_e              op_in, op_q;
  step_mode_e       mode;
  logic             sign1, sign2, div_zero;
  logic             s1_in, s2_in;
  logic             accept, early;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] acc, opnd, quo, acc_next, quo_next;
  logic [WIDTH-1:0] mag1, mag2;
  logic [2*WIDTH-1:0] prod, prod_fix;
  logic [WIDTH-1:0] quo_fix, rem_fix, result;

  always_comb begin
    op_in = op_e'(op);
    s1_in = rs1_signed(op_in) && in1[WIDTH-1];
    s2_in = rs2_signed(op_in) && in2[WIDTH-1];
    mag1  = s1_in ? -in1 : in1;
    mag2  = s2_in ? -in2 : in2;
  end

`ifdef MULDIV_EARLY_OUT_EN
  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};
  logic [WIDTH-1:0] early_res;
  logic             ovf_in;

  always_comb begin
    early     = 1'b0;
    early_res = '0;
    ovf_in    = (op_in inside {OP_DIV, OP_REM}) && (in1 == MOST_NEG) && (in2 == '1);
    if (is_div(op_in)) begin
      if (in2 == '0) begin
        early     = 1'b1;
        early_res = (op_in inside {OP_DIV, OP_DIVU}) ? '1 : in1;
      end else if (ovf_in) begin
        early     = 1'b1;
        early_res = (op_in == OP_DIV) ? in1 : '0;
      end
    end else if (in1 == '0 || in2 == '0) begin
      early = 1'b1;
    end
  end
`else
  assign early = 1'b0;
`endif

  always_comb begin
    mode = is_div(op_q) ? STEP_DIV : STEP_MUL;
  end

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .mode     (mode),
    .acc      (acc),
    .opnd     (opnd),
    .quo      (quo),
    .acc_next (acc_next),
    .quo_next (quo_next)
  );

  // Division by zero keeps the all-ones quotient magnitude unnegated so a
  // negative dividend still yields -1; the remainder magnitude is the
  // dividend and regains its sign like any other remainder.
  always_comb begin
    prod     = {acc, quo};
    prod_fix = (sign1 ^ sign2) ? -prod : prod;
    quo_fix  = ((sign1 ^ sign2) && !div_zero) ? -quo : quo;
    rem_fix  = sign1 ? -acc : acc;
    case (op_q)
      OP_MUL:                       result = prod_fix[WIDTH-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: result = prod_fix[2*WIDTH-1:WIDTH];
      OP_DIV, OP_DIVU:              result = quo_fix;
      OP_REM, OP_REMU:              result = rem_fix;
      default:                      result = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n   = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid && !flush) begin
          accept  = 1'b1;
          state_n = early ? DONE : BUSY;
        end
      end
      BUSY:  if (cnt == LAST) state_n = FIXUP;
      FIXUP: state_n = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
    if (flush) state_n = IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_q     <= OP_MUL;
      sign1    <= 1'b0;
      sign2    <= 1'b0;
      div_zero <= 1'b0;
      acc      <= '0;
      opnd     <= '0;
      quo      <= '0;
      cnt      <= '0;
      out      <= '0;
    end else if (!flush) begin
      case (state)
        IDLE: begin
          if (accept) begin
            op_q     <= op_in;
            sign1    <= s1_in;
            sign2    <= s2_in;
            div_zero <= (in2 == '0);
            acc      <= '0;
            cnt      <= '0;
            if (is_div(op_in)) begin
              opnd <= mag2;
              quo  <= mag1;
            end else begin
              opnd <= mag1;
              quo  <= mag2;
            end
`ifdef MULDIV_EARLY_OUT_EN
            if (early) out <= early_res;
`endif
          end
        end
        BUSY: begin
          acc <= acc_next;
          quo <= quo_next;
          cnt <= cnt + 1'b1;
        end
        FIXUP:   out <= result;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_muldiv.sv
// Self-checking bench for alu_muldiv (WIDTH=32): directed RV32M vectors,
// randomized operations against a 64-bit arithmetic reference model,
// backpressure, back-to-back, flush and mid-operation reset.
module tb_alu_muldiv;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  op = '0;
  logic [31:0] in1 = '0;
  logic [31:0] in2 = '0;
  logic        flush = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  alu_muldiv #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .in1       (in1),
    .in2       (in2),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out)
  );

  // Reference: RV32M semantics from plain 64-bit arithmetic.
  function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    longint          sa, sb, p;
    longint unsigned up;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    up = {32'b0, a} * {32'b0, b};
    case (f)
      3'd0: return up[31:0];
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * longint'({32'b0, b}); return p[63:32]; end
      3'd3: return up[63:32];
      3'd4: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
        p = sa / sb; return p[31:0];
      end
      3'd5: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 32'd0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        p = sa % sb; return p[31:0];
      end
      default: return (b == 32'd0) ? a : a % b;
    endcase
  endfunction

  // Edges after the accepting edge until out_valid is seen.
  function automatic int exp_lat(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
`ifdef MULDIV_EARLY_OUT_EN
    if (f[2] && b == 32'd0) return 0;
    if ((f == 3'd4 || f == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 0;
    if (!f[2] && (a == 32'd0 || b == 32'd0)) return 0;
`endif
    return 33;
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  // Issues one request, scrambles inputs after acceptance, waits for out_valid.
  task automatic do_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] res, output int lat, output bit busy_ready);
    @(negedge clk);
    in_valid = 1'b1; op = f; in1 = a; in2 = b;
    @(negedge clk);
    in_valid = 1'b0; op = 3'($urandom); in1 = $urandom; in2 = $urandom;
    lat = 0;
    busy_ready = 1'b0;
    while (!out_valid && lat < 200) begin
      if (in_ready) busy_ready = 1'b1;
      @(negedge clk);
      lat++;
    end
    res = out;
  endtask

  task automatic handoff();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset in_ready: got %b want 1", in_ready); end
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset out_valid: got %b want 0", out_valid); end
    n_cmp++; if (out !== 32'd0) begin n_bad++; $display("FAIL reset out: got %h want 00000000", out); end
    rst = 1'b0;
  endtask

  typedef struct { logic [2:0] f; logic [31:0] a; logic [31:0] b; logic [31:0] e; } vec_t;

  task automatic test_directed();
    vec_t vecs[16];
    logic [31:0] res;
    int lat;
    bit br;
    vecs = '{
      '{3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB},
      '{3'd1, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000},
      '{3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE},
      '{3'd2, 32'hFFFF_FFFF,  32'd2,         32'hFFFF_FFFF},
      '{3'd4, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD},
      '{3'd6, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF},
      '{3'd5, 32'd7,          32'd2,         32'd3},
      '{3'd7, 32'd7,          32'd2,         32'd1},
      '{3'd4, 32'd5,          32'd0,         32'hFFFF_FFFF},
      '{3'd6, 32'd5,          32'd0,         32'd5},
      '{3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000},
      '{3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0},
      '{3'd4, 32'hFFFF_FFFB,  32'd0,         32'hFFFF_FFFF},
      '{3'd5, 32'd5,          32'd0,         32'hFFFF_FFFF},
      '{3'd0, 32'd0,          32'd1234,      32'd0},
      '{3'd7, 32'd9,          32'd0,         32'd9}
    };
    for (int i = 0; i < 16; i++) begin
      do_op(vecs[i].f, vecs[i].a, vecs[i].b, res, lat, br);
      handoff();
      n_cmp++; if (res !== vecs[i].e) begin n_bad++; $display("FAIL directed[%0d] out: got %h want %h", i, res, vecs[i].e); end
      n_cmp++; if (lat !== exp_lat(vecs[i].f, vecs[i].a, vecs[i].b)) begin
        n_bad++; $display("FAIL directed[%0d] latency: got %0d want %0d", i, lat, exp_lat(vecs[i].f, vecs[i].a, vecs[i].b)); end
      n_cmp++; if (br !== 1'b0) begin n_bad++; $display("FAIL directed[%0d] in_ready while busy: got 1 want 0", i); end
    end
  endtask

  task automatic test_random();
    logic [2:0]  f;
    logic [31:0] a, b, res;
    int lat;
    bit br;
    for (int i = 0; i < 150; i++) begin
      f = 3'($urandom_range(0, 7));
      a = pick();
      b = pick();
      do_op(f, a, b, res, lat, br);
      handoff();
      n_cmp++; if (res !== model(f, a, b)) begin
        n_bad++; $display("FAIL random[%0d] op=%0d a=%h b=%h out: got %h want %h", i, f, a, b, res, model(f, a, b)); end
      n_cmp++; if (lat !== exp_lat(f, a, b)) begin
        n_bad++; $display("FAIL random[%0d] latency: got %0d want %0d", i, lat, exp_lat(f, a, b)); end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] a, b, res;
    int lat;
    bit br;
    a = $urandom;
    b = $urandom_range(1, 1000);
    do_op(3'd5, a, b, res, lat, br);
    n_cmp++; if (res !== a / b) begin n_bad++; $display("FAIL backpressure out: got %h want %h", res, a / b); end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_cmp++; if (out_valid !== 1'b1 || out !== a / b || in_ready !== 1'b0) begin
        n_bad++; $display("FAIL backpressure hold[%0d]: got valid=%b out=%h ready=%b want valid=1 out=%h ready=0",
                          i, out_valid, out, in_ready, a / b); end
    end
    out_ready = 1'b1;
    #1;
    n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL handoff-cycle in_ready: got %b want 0", in_ready); end
    @(negedge clk);
    out_ready = 1'b0;
    n_cmp++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_bad++; $display("FAIL after handoff: got ready=%b valid=%b want ready=1 valid=0", in_ready, out_valid); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] a, b, res;
    int lat;
    bit br;
    for (int i = 0; i < 4; i++) begin
      a = $urandom;
      b = $urandom;
      do_op(3'(i), a, b, res, lat, br);
      handoff();
      n_cmp++; if (res !== model(3'(i), a, b)) begin
        n_bad++; $display("FAIL back_to_back[%0d] out: got %h want %h", i, res, model(3'(i), a, b)); end
    end
  endtask

  // kind 0: flush, kind 1: reset, kind 2: flush with request in IDLE
  task automatic test_abort(input int kind);
    logic [31:0] res;
    int lat;
    bit br, seen;
    string nm;
    nm = (kind == 1) ? "rst" : (kind == 0) ? "flush" : "flush_idle";
    @(negedge clk);
    in_valid = 1'b1; op = 3'd4; in1 = 32'd100; in2 = 32'd7;
    if (kind == 2) begin
      flush = 1'b1;
      @(negedge clk);
      in_valid = 1'b0; flush = 1'b0;
    end else begin
      @(negedge clk);
      in_valid = 1'b0;
      repeat (9) @(negedge clk);
      if (kind == 1) rst = 1'b1; else flush = 1'b1;
      @(negedge clk);
      rst = 1'b0; flush = 1'b0;
    end
    n_cmp++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_bad++; $display("FAIL %s state: got ready=%b valid=%b want ready=1 valid=0", nm, in_ready, out_valid); end
    if (kind == 1) begin
      n_cmp++; if (out !== 32'd0) begin n_bad++; $display("FAIL rst out: got %h want 00000000", out); end
    end
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    n_cmp++; if (seen !== 1'b0) begin n_bad++; $display("FAIL %s out_valid rose: got 1 want 0", nm); end
    do_op(3'd4, 32'hFFFF_FF9C, 32'd7, res, lat, br);
    handoff();
    n_cmp++; if (res !== 32'hFFFF_FFF2) begin n_bad++; $display("FAIL %s next op out: got %h want fffffff2", nm, res); end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_backpressure();
    test_back_to_back();
    test_abort(0);
    test_abort(1);
    test_abort(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
